// File: rtl/datapath_if.sv
// datapath_if: control-unit and memory bus of the MiniSRC datapath
//   master : control unit / testbench side (drives controls and memory read data)
//   slave  : datapath side (drives memory address/data and condition flags)
interface datapath_if;
   logic [31:0] iMemData;
   logic [31:0] oMemAddr;
   logic [31:0] oMemData;
   logic        iPC_nRst;
   logic        iPC_en;
   logic        iPC_jmp;
   logic        iPC_loadRA;
   logic        iPC_loadImm;
   logic        iRF_Write;
   logic [3:0]  iRF_AddrA;
   logic [3:0]  iRF_AddrB;
   logic [3:0]  iRF_AddrC;
   logic        iRWB_en;
   logic [3:0]  iALU_Ctrl;
   logic        iRA_en;
   logic        iRB_en;
   logic        iRZH_en;
   logic        iRZL_en;
   logic        iRAS_en;
   logic        iMUX_BIS;
   logic        iMUX_RZHS;
   logic        iMUX_WBM;
   logic        iMUX_WBP;
   logic        iMUX_MAP;
   logic        iMUX_ASS;
   logic [31:0] iImm32;
   logic        oJ_zero;
   logic        oJ_nZero;
   logic        oJ_pos;
   logic        oJ_neg;
   logic        oALU_zero;
   logic        oALU_neg;

   modport master (
      output iMemData, iPC_nRst, iPC_en, iPC_jmp, iPC_loadRA, iPC_loadImm,
             iRF_Write, iRF_AddrA, iRF_AddrB, iRF_AddrC, iRWB_en, iALU_Ctrl,
             iRA_en, iRB_en, iRZH_en, iRZL_en, iRAS_en,
             iMUX_BIS, iMUX_RZHS, iMUX_WBM, iMUX_WBP, iMUX_MAP, iMUX_ASS, iImm32,
      input  oMemAddr, oMemData, oJ_zero, oJ_nZero, oJ_pos, oJ_neg,
             oALU_zero, oALU_neg
   );

   modport slave (
      input  iMemData, iPC_nRst, iPC_en, iPC_jmp, iPC_loadRA, iPC_loadImm,
             iRF_Write, iRF_AddrA, iRF_AddrB, iRF_AddrC, iRWB_en, iALU_Ctrl,
             iRA_en, iRB_en, iRZH_en, iRZL_en, iRAS_en,
             iMUX_BIS, iMUX_RZHS, iMUX_WBM, iMUX_WBP, iMUX_MAP, iMUX_ASS, iImm32,
      output oMemAddr, oMemData, oJ_zero, oJ_nZero, oJ_pos, oJ_neg,
             oALU_zero, oALU_neg
   );
endinterface

// File: rtl/datapath.sv
// datapath: MiniSRC register-transfer datapath (PC, 16x32 RF, RA/RB, ALU, RZH/RZL, RAS, RWB)
//   iClk : rising-edge clock
//   nRst : asynchronous active-high reset, clears all state
//   bus  : datapath_if.slave -- control enables/selects/opcode, immediate, memory
//          read data in; memory address/write data and branch/ALU flags out
//   Optional MUL/DIV (opcodes 9/10) built only when DATAPATH_MULDIV_EN is defined;
//   otherwise those opcodes yield zero.
module datapath (
   input  logic      iClk,
   input  logic      nRst,
   datapath_if.slave bus
);
   logic [31:0] rf [16];
   logic [31:0] pc, ra, rb, rzh, rzl, ras, rwb;
   logic [31:0] rd_a, rd_b, rz, alu_hi, alu_lo;
   logic [63:0] dbl, ror_w, rol_w;
   logic [4:0]  sh;

   assign rd_a  = rf[bus.iRF_AddrA];
   assign rd_b  = rf[bus.iRF_AddrB];
   assign rz    = bus.iMUX_RZHS ? rzh : rzl;
   assign sh    = rb[4:0];
   // rotates take the matching half of RA concatenated with itself
   assign dbl   = {ra, ra};
   assign ror_w = dbl >> sh;
   assign rol_w = dbl << sh;

`ifdef DATAPATH_MULDIV_EN
   logic [63:0]        prod;
   logic [31:0]        dvs;
   logic signed [31:0] quo_s, rem_s;
   logic [31:0]        quo, rem;
   assign prod  = $signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb});
   // divisor forced to 1 for RB=0 and RB=-1 so the raw divider never sees
   // divide-by-zero or the MIN/-1 overflow; those cases are muxed in below
   assign dvs   = (rb == '0 || rb == '1) ? 32'd1 : rb;
   assign quo_s = $signed(ra) / $signed(dvs);
   assign rem_s = $signed(ra) % $signed(dvs);
   assign quo   = rb == '0 ? '1 : rb == '1 ? 32'd0 - ra : quo_s;
   assign rem   = rb == '0 ? ra : rb == '1 ? 32'd0 : rem_s;
`endif

   always_comb begin
      alu_hi = '0;
      alu_lo = '0;
      case (bus.iALU_Ctrl)
         4'd0:  alu_lo = ra + rb;
         4'd1:  alu_lo = ra - rb;
         4'd2:  alu_lo = ra & rb;
         4'd3:  alu_lo = ra | rb;
         4'd4:  alu_lo = ra >> sh;
         4'd5:  alu_lo = $signed(ra) >>> sh;
         4'd6:  alu_lo = ra << sh;
         4'd7:  alu_lo = ror_w[31:0];
         4'd8:  alu_lo = rol_w[63:32];
`ifdef DATAPATH_MULDIV_EN
         4'd9:  {alu_hi, alu_lo} = prod;
         4'd10: {alu_hi, alu_lo} = {rem, quo};
`endif
         4'd11: alu_lo = 32'd0 - rb;
         4'd12: alu_lo = ~rb;
         4'd13: alu_lo = ra;
         4'd14: alu_lo = rb;
         default: alu_lo = '0;
      endcase
   end

   always_ff @(posedge iClk or posedge nRst) begin
      if (nRst) begin
         rf  <= '{default: '0};
         pc  <= '0;
         ra  <= '0;
         rb  <= '0;
         rzh <= '0;
         rzl <= '0;
         ras <= '0;
         rwb <= '0;
      end else begin
         if (bus.iRF_Write) rf[bus.iRF_AddrC] <= rwb;
         if (bus.iRA_en)    ra  <= rd_a;
         if (bus.iRB_en)    rb  <= bus.iMUX_BIS ? bus.iImm32 : rd_b;
         if (bus.iRZH_en)   rzh <= alu_hi;
         if (bus.iRZL_en)   rzl <= alu_lo;
         if (bus.iRAS_en)   ras <= rz;
         if (bus.iRWB_en)
            rwb <= bus.iMUX_WBM ? bus.iMemData :
                   bus.iMUX_WBP ? pc :
                   bus.iMUX_ASS ? ras : rz;
         // synchronous PC clear overrides every other PC control
         if (!bus.iPC_nRst)
            pc <= '0;
         else if (bus.iPC_en)
            pc <= (bus.iPC_jmp && bus.iPC_loadRA)  ? ra :
                  (bus.iPC_jmp && bus.iPC_loadImm) ? pc + bus.iImm32 : pc + 32'd1;
      end
   end

   assign bus.oMemAddr  = bus.iMUX_MAP ? pc : rzl;
   assign bus.oMemData  = rd_b;
   assign bus.oJ_zero   = ra == '0;
   assign bus.oJ_nZero  = ra != '0;
   assign bus.oJ_neg    = ra[31];
   assign bus.oJ_pos    = ~ra[31] & (ra != '0);
   assign bus.oALU_zero = alu_lo == '0;
   assign bus.oALU_neg  = alu_lo[31];
endmodule

// File: tb/tb_datapath.sv
// tb_datapath: table-driven ALU vectors with a scoreboard queue, plus hand sequences
// for register-op timing, PC control, write-back muxing, flags and async reset.
module tb_datapath;
   logic iClk = 1'b0;
   logic nRst = 1'b1;
   datapath_if bus ();
   datapath dut (.iClk(iClk), .nRst(nRst), .bus(bus.slave));
   always #5 iClk = ~iClk;

`ifdef DATAPATH_MULDIV_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a, b, lo, hi;
   } vec_t;
   typedef struct {
      logic [31:0] lo, hi;
      logic        z, ng;
   } exp_t;

   vec_t vec[$];
   exp_t sb[$];
   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge iClk);
      #1;
   endtask

   task automatic idle();
      bus.iMemData = '0;  bus.iImm32 = '0;
      bus.iPC_nRst = 1'b1; bus.iPC_en = 1'b0; bus.iPC_jmp = 1'b0;
      bus.iPC_loadRA = 1'b0; bus.iPC_loadImm = 1'b0;
      bus.iRF_Write = 1'b0; bus.iRF_AddrA = '0; bus.iRF_AddrB = '0; bus.iRF_AddrC = '0;
      bus.iRWB_en = 1'b0; bus.iALU_Ctrl = '0;
      bus.iRA_en = 1'b0; bus.iRB_en = 1'b0; bus.iRZH_en = 1'b0; bus.iRZL_en = 1'b0;
      bus.iRAS_en = 1'b0;
      bus.iMUX_BIS = 1'b0; bus.iMUX_RZHS = 1'b0; bus.iMUX_WBM = 1'b0;
      bus.iMUX_WBP = 1'b0; bus.iMUX_MAP = 1'b0; bus.iMUX_ASS = 1'b0;
   endtask

   // external load: iMemData -> RWB -> R[r]
   task automatic load_reg(input logic [3:0] r, input logic [31:0] v);
      idle();
      bus.iMemData = v; bus.iMUX_WBM = 1'b1; bus.iRWB_en = 1'b1;
      step();
      idle();
      bus.iRF_Write = 1'b1; bus.iRF_AddrC = r;
      step();
      idle();
   endtask

   // RWB (already loaded) -> R[r], then read it back on oMemData
   task automatic wb_check(input string name, input logic [3:0] r, input logic [31:0] req);
      idle();
      bus.iRF_Write = 1'b1; bus.iRF_AddrC = r;
      step();
      idle();
      bus.iRF_AddrB = r;
      #1;
      chk(name, bus.oMemData, req);
   endtask

   initial begin
      exp_t e;
      idle();
      vec.push_back('{4'd0,  32'h0000_0022, 32'h0000_0005, 32'h0000_0027, 32'h0});
      vec.push_back('{4'd1,  32'h0000_0022, 32'h0000_0022, 32'h0000_0000, 32'h0});
      vec.push_back('{4'd1,  32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0});
      vec.push_back('{4'd2,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 32'h0});
      vec.push_back('{4'd3,  32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 32'h0});
      vec.push_back('{4'd4,  32'h8000_0010, 32'h0000_0004, 32'h0800_0001, 32'h0});
      vec.push_back('{4'd5,  32'h8000_0010, 32'h0000_0004, 32'hF800_0001, 32'h0});
      vec.push_back('{4'd6,  32'h0000_0022, 32'h0000_0024, 32'h0000_0220, 32'h0});
      vec.push_back('{4'd7,  32'h1234_5678, 32'h0000_0008, 32'h7812_3456, 32'h0});
      vec.push_back('{4'd7,  32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 32'h0});
      vec.push_back('{4'd8,  32'h1234_5678, 32'h0000_0008, 32'h3456_7812, 32'h0});
      vec.push_back('{4'd9,  32'hFFFF_FFFE, 32'h0000_0003,
                      MD ? 32'hFFFF_FFFA : 32'h0, MD ? 32'hFFFF_FFFF : 32'h0});
      vec.push_back('{4'd10, 32'h0000_0007, 32'h0000_0002,
                      MD ? 32'h0000_0003 : 32'h0, MD ? 32'h0000_0001 : 32'h0});
      vec.push_back('{4'd10, 32'h0000_0007, 32'h0000_0000,
                      MD ? 32'hFFFF_FFFF : 32'h0, MD ? 32'h0000_0007 : 32'h0});
      vec.push_back('{4'd10, 32'hFFFF_FFF9, 32'h0000_0002,
                      MD ? 32'hFFFF_FFFD : 32'h0, MD ? 32'hFFFF_FFFF : 32'h0});
      vec.push_back('{4'd11, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFB, 32'h0});
      vec.push_back('{4'd12, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0});
      vec.push_back('{4'd13, 32'h0000_1234, 32'h0000_0001, 32'h0000_1234, 32'h0});
      vec.push_back('{4'd14, 32'h0000_1234, 32'h0000_0000, 32'h0000_0000, 32'h0});
      vec.push_back('{4'd15, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 32'h0});

      // reset state
      #1;
      chk("rst memaddr rzl", bus.oMemAddr, 32'h0);
      bus.iMUX_MAP = 1'b1; #1;
      chk("rst memaddr pc", bus.oMemAddr, 32'h0);
      chk("rst memdata", bus.oMemData, 32'h0);
      chk("rst j_zero", bus.oJ_zero, 1'b1);
      chk("rst j_nzero", bus.oJ_nZero, 1'b0);
      chk("rst j_pos", bus.oJ_pos, 1'b0);
      chk("rst j_neg", bus.oJ_neg, 1'b0);
      chk("rst alu_zero add", bus.oALU_zero, 1'b1);
      bus.iALU_Ctrl = 4'd12; #1;
      chk("rst alu_zero not", bus.oALU_zero, 1'b0);
      chk("rst alu_neg not", bus.oALU_neg, 1'b1);
      idle();
      step();
      nRst = 1'b0;
      step();

      // ALU vectors: expectations pushed at stimulus, popped at observation
      foreach (vec[i]) begin
         load_reg(4'd1, vec[i].a);
         bus.iRF_AddrA = 4'd1; bus.iMUX_BIS = 1'b1; bus.iImm32 = vec[i].b;
         bus.iRA_en = 1'b1; bus.iRB_en = 1'b1; bus.iALU_Ctrl = vec[i].op;
         sb.push_back('{vec[i].lo, vec[i].hi, vec[i].lo == 32'h0, vec[i].lo[31]});
         step();
         idle();
         bus.iALU_Ctrl = vec[i].op; bus.iRZH_en = 1'b1; bus.iRZL_en = 1'b1;
         #1;
         e = sb.pop_front();
         chk($sformatf("v%0d op%0d alu_zero", i, vec[i].op), bus.oALU_zero, e.z);
         chk($sformatf("v%0d op%0d alu_neg", i, vec[i].op), bus.oALU_neg, e.ng);
         step();
         idle();
         #1;
         chk($sformatf("v%0d op%0d lo", i, vec[i].op), bus.oMemAddr, e.lo);
         bus.iMUX_RZHS = 1'b1; bus.iRWB_en = 1'b1;
         step();
         wb_check($sformatf("v%0d op%0d hi", i, vec[i].op), 4'd15, e.hi);
      end

      // 5-step register op: R4 = R3 << R7[4:0]
      load_reg(4'd3, 32'h22);
      load_reg(4'd7, 32'h24);
      bus.iRF_AddrA = 4'd3; bus.iRF_AddrB = 4'd7; bus.iRA_en = 1'b1; bus.iRB_en = 1'b1;
      step();
      idle(); bus.iALU_Ctrl = 4'd6; bus.iRZL_en = 1'b1; #1;
      chk("sll alu_zero", bus.oALU_zero, 1'b0);
      step();
      idle(); bus.iRWB_en = 1'b1;
      step();
      idle(); bus.iRF_Write = 1'b1; bus.iRF_AddrC = 4'd4; bus.iRF_AddrB = 4'd4; #1;
      chk("no bypass", bus.oMemData, 32'h0);
      step();
      idle(); bus.iRF_AddrB = 4'd4; #1;
      chk("sll r4", bus.oMemData, 32'h220);

      // PC sequencing
      idle(); bus.iPC_en = 1'b1;
      step();
      step();
      idle(); bus.iMUX_MAP = 1'b1; #1;
      chk("pc inc2", bus.oMemAddr, 32'h2);
      bus.iPC_en = 1'b1; bus.iPC_jmp = 1'b1; bus.iPC_loadImm = 1'b1; bus.iImm32 = '1;
      step();
      idle(); bus.iMUX_MAP = 1'b1; #1;
      chk("pc imm -1", bus.oMemAddr, 32'h1);
      load_reg(4'd2, 32'h40);
      bus.iRF_AddrA = 4'd2; bus.iRA_en = 1'b1;
      step();
      idle();
      bus.iPC_en = 1'b1; bus.iPC_jmp = 1'b1; bus.iPC_loadRA = 1'b1;
      bus.iPC_loadImm = 1'b1; bus.iImm32 = 32'h5;
      step();
      idle(); step();
      bus.iMUX_MAP = 1'b1; #1;
      chk("pc loadRA hold", bus.oMemAddr, 32'h40);
      idle(); bus.iMUX_WBP = 1'b1; bus.iRWB_en = 1'b1;
      step();
      wb_check("wbp rwb", 4'd5, 32'h40);
      bus.iMemData = 32'h99; bus.iMUX_WBM = 1'b1; bus.iMUX_WBP = 1'b1; bus.iRWB_en = 1'b1;
      step();
      wb_check("wbm priority", 4'd5, 32'h99);
      bus.iPC_nRst = 1'b0; bus.iPC_en = 1'b1; bus.iPC_jmp = 1'b1; bus.iPC_loadRA = 1'b1;
      step();
      idle(); bus.iMUX_MAP = 1'b1; #1;
      chk("pc sync clear", bus.oMemAddr, 32'h0);

      // RAS keeps its value while RZL changes
      idle(); bus.iRAS_en = 1'b1;
      step();
      idle(); bus.iALU_Ctrl = 4'd15; bus.iRZL_en = 1'b1;
      step();
      idle(); bus.iMUX_ASS = 1'b1; bus.iRWB_en = 1'b1;
      step();
      wb_check("ras wb", 4'd6, 32'h220);

      // branch flags on RA
      load_reg(4'd1, 32'h8000_0000);
      bus.iRF_AddrA = 4'd1; bus.iRA_en = 1'b1; step(); idle(); #1;
      chk("neg j_neg", bus.oJ_neg, 1'b1);
      chk("neg j_nzero", bus.oJ_nZero, 1'b1);
      chk("neg j_pos", bus.oJ_pos, 1'b0);
      chk("neg j_zero", bus.oJ_zero, 1'b0);
      load_reg(4'd1, 32'h0);
      bus.iRF_AddrA = 4'd1; bus.iRA_en = 1'b1; step(); idle(); #1;
      chk("zero j_zero", bus.oJ_zero, 1'b1);
      chk("zero j_pos", bus.oJ_pos, 1'b0);
      load_reg(4'd1, 32'h5);
      bus.iRF_AddrA = 4'd1; bus.iRA_en = 1'b1; step(); idle(); #1;
      chk("pos j_pos", bus.oJ_pos, 1'b1);
      chk("pos j_neg", bus.oJ_neg, 1'b0);

      // asynchronous reset between edges
      idle(); bus.iPC_en = 1'b1;
      step(); step(); step();
      idle(); bus.iMUX_MAP = 1'b1; bus.iRF_AddrB = 4'd5; #1;
      chk("pre-rst pc", bus.oMemAddr, 32'h3);
      chk("pre-rst r5", bus.oMemData, 32'h99);
      #1 nRst = 1'b1;
      #1;
      chk("async rst pc", bus.oMemAddr, 32'h0);
      chk("async rst r5", bus.oMemData, 32'h0);
      chk("async rst j_zero", bus.oJ_zero, 1'b1);
      step();
      nRst = 1'b0;
      step();
      #1;
      chk("post-rst pc", bus.oMemAddr, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
